// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider: each channel emits a one-cycle tick
// and a near-50% square wave per period, with shadowed period reload and global sync.
`timescale 1ns/1ps
module multi_clock_divider #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] period,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       sq
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] per;
    logic [WIDTH-1:0] high;
    logic [WIDTH:0]   cnt_inc;
    logic             tick_r;
    logic             sq_r;

    assign per     = period[i*WIDTH +: WIDTH];
    // High time of sq is ceil(pa/2), so odd periods lean high.
    assign high    = pa - (pa >> 1);
    assign cnt_inc = {1'b0, cnt} + {1'b0, ONE};

    // pa only follows period when idle, disabled, synced or at wrap, so a
    // running period is never cut short or stretched.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        pa     <= '0;
        tick_r <= 1'b0;
        sq_r   <= 1'b0;
      end else if (!en[i]) begin
        cnt    <= '0;
        pa     <= per;
        tick_r <= 1'b0;
        sq_r   <= 1'b0;
      end else if (sync) begin
        cnt    <= '0;
        pa     <= per;
        tick_r <= 1'b0;
        sq_r   <= (per != '0);
      end else if (pa == '0) begin
        cnt    <= '0;
        pa     <= per;
        tick_r <= 1'b0;
        sq_r   <= 1'b0;
      end else if (cnt == pa - ONE) begin
        cnt    <= '0;
        pa     <= per;
        tick_r <= 1'b1;
        sq_r   <= 1'b1;
      end else begin
        cnt    <= cnt_inc[WIDTH-1:0];
        tick_r <= 1'b0;
        sq_r   <= (cnt_inc < {1'b0, high});
      end
    end

    assign tick[i] = tick_r;
    assign sq[i]   = sq_r;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: basic ratios, mid-period reload,
// sync alignment and suppression, enable drop, and asynchronous reset.
`timescale 1ns/1ps
module tb_multi_clock_divider;

  localparam int CHANNELS = 4;
  localparam int WIDTH    = 32;

  logic                      clk;
  logic                      rst_n;
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS*WIDTH-1:0] period;
  logic                      sync;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       sq;

  int tests_run;
  int tests_failed;

  multi_clock_divider #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .period (period),
    .sync   (sync),
    .tick   (tick),
    .sq     (sq)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-derived outputs {ch3,ch2,ch1,ch0} after each edge A1..A11,
  // with periods ch0=4, ch1=5, ch2=1, ch3=0 enabled together from halt.
  logic [3:0] basic_tick [11] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h5, 4'h6, 4'h4, 4'h4, 4'h5, 4'h4, 4'h6};
  logic [3:0] basic_sq   [11] = '{4'h0, 4'h7, 4'h6, 4'h4, 4'h5, 4'h7, 4'h6, 4'h6, 4'h5, 4'h5, 4'h6};
  // ch0 period 8 switched to 3 at cnt=2: edges B1..B14.
  logic       reload_sq  [14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Caller is at a negedge with the DUT freshly out of reset.
  task automatic run_basic(input string tag);
    en     = 4'b1111;
    period = {32'd0, 32'd1, 32'd5, 32'd4};
    sync   = 1'b0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      check({tag, "_tick"}, 32'(tick), 32'(basic_tick[k]));
      check({tag, "_sq"},   32'(sq),   32'(basic_sq[k]));
    end
  endtask

  initial begin
    logic [1:0] exp2;
    logic [1:0] sq2;
    tests_run    = 0;
    tests_failed = 0;
    en     = '0;
    period = '0;
    sync   = 1'b0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;

    @(negedge clk);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_sq",   32'(sq),   32'd0);
    rst_n = 1'b1;
    run_basic("basic");

    // Mid-period reload on ch0: 8 -> 3 once cnt reaches 2.
    en     = 4'b0000;
    period = {32'd0, 32'd0, 32'd0, 32'd8};
    @(negedge clk);
    check("disabled_tick", 32'(tick), 32'd0);
    check("disabled_sq",   32'(sq),   32'd0);
    en = 4'b0001;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check("reload_tick", 32'(tick), (k == 8 || k == 11 || k == 14) ? 32'd1 : 32'd0);
      check("reload_sq",   32'(sq),   32'(reload_sq[k-1]));
      if (k == 2) period[31:0] = 32'd3;
    end

    // ch0=6, ch1=9 free-run out of phase, then a one-cycle sync.
    en     = 4'b0011;
    period = {32'd0, 32'd0, 32'd9, 32'd6};
    repeat (5) @(negedge clk);
    sync = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      sync = 1'b0;
      exp2[0] = (k >= 7)  && ((k - 7)  % 6 == 0);
      exp2[1] = (k >= 10) && ((k - 10) % 9 == 0);
      sq2[0]  = ((k - 1) % 6) < 3;
      sq2[1]  = ((k - 1) % 9) < 5;
      check("sync_tick", 32'(tick), 32'(exp2));
      check("sync_sq",   32'(sq),   32'(sq2));
      if (k == 24) sync = 1'b1;
    end

    // Edge S25 is a ch0 wrap edge; sync must swallow its tick.
    @(negedge clk);
    sync = 1'b0;
    check("sync_wrap_tick", 32'(tick), 32'd0);
    check("sync_wrap_sq",   32'(sq),   32'd3);

    // Drop ch1 enable mid-period, then re-enable for a full 9-cycle period.
    for (int k = 26; k <= 37; k++) begin
      @(negedge clk);
      exp2[0] = ((k - 25) % 6) == 0;
      exp2[1] = (k == 37);
      sq2[0]  = ((k - 25) % 6) < 3;
      if (k <= 27)      sq2[1] = 1'b1;
      else if (k == 28) sq2[1] = 1'b0;
      else              sq2[1] = (k <= 32) || (k == 37);
      check("enable_tick", 32'(tick), 32'(exp2));
      check("enable_sq",   32'(sq),   32'(sq2));
      if (k == 27) en = 4'b0001;
      if (k == 28) en = 4'b0011;
    end

    // Asynchronous reset mid-cycle while both ticks are high.
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_tick", 32'(tick), 32'd0);
    check("async_rst_sq",   32'(sq),   32'd0);
    en     = '0;
    period = '0;
    @(negedge clk);
    check("hold_rst_tick", 32'(tick), 32'd0);
    check("hold_rst_sq",   32'(sq),   32'd0);
    rst_n = 1'b1;
    run_basic("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parametrised, multi-channel successor to the single-output clock divider. Each of `CHANNELS` independent channels divides the system clock by its own runtime-programmable period. Each channel produces both a one-cycle tick pulse and a near-50% square wave. Per-channel enable, glitch-free period reload at period boundaries, and a global phase-sync restart let the synth voices and sequencer timebases share one block and stay phase-aligned.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent divider channels (≥1).
- `WIDTH`, 32: period and counter width in bits (2..32).

Ports:
- `clk`  input  1: system clock; all state changes on its rising edge.
- `rst_n`  input  1: asynchronous active-low reset.
- `en`  input  CHANNELS: per-channel enable; bit i controls channel i.
- `period`  input  CHANNELS*WIDTH: per-channel divide ratio, unsigned. Channel i uses bits [i*WIDTH +: WIDTH].
- `sync`  input  1: synchronous global restart of all enabled channels.
- `tick`  output  CHANNELS: one-cycle pulse, once per period.
- `sq`  output  CHANNELS: square wave with period P cycles.

## Operation
- Per channel state:
  - `cnt[WIDTH]`
  - active period `pa[WIDTH]`, a shadow copy of `period`
  - registered `tick` and `sq`
- Define H = pa − (pa >> 1), i.e. ceil(pa/2). This is the high-time of `sq`.
- Reset (`rst_n`=0, asynchronous): cnt=0, pa=0, tick=0, sq=0 on all channels.
- Per-edge update priority, highest first:
  1. `en[i]`=0 (disabled): cnt←0, pa←period_i, tick←0, sq←0.
  2. `sync`=1: cnt←0, pa←period_i, tick←0, sq←(period_i≠0).
  3. pa=0 (halted): cnt←0, pa←period_i, tick←0, sq←0. A new nonzero period starts counting on the following edge, beginning at cnt=0.
  4. cnt = pa−1 (wrap): cnt←0, tick←1, pa←period_i, sq←1.
  5. Otherwise: cnt←cnt+1, tick←0, sq←(cnt+1 < H).
- Period reload:
  - While running, a new `period` value takes effect only at wrap, at sync, or while disabled/halted.
  - Changing `period` mid-period never truncates or stretches the current period.
- Arithmetic: cnt < pa ≤ 2^WIDTH−1 always, so no overflow. All compares are unsigned WIDTH-bit. `cnt+1` is evaluated at WIDTH+1 bits.
- pa=1: wrap fires every edge, so tick is held at 1 and sq is held at 1.
- pa=2: tick is 1 every second cycle, and sq toggles every cycle.
- Odd pa: sq is high for (pa+1)/2 cycles and low for (pa−1)/2 cycles.
- Channels are fully independent. `sync` is the only shared control.

## Timing
- Outputs are registered. There is no combinational path from any input to any output.
- Let E0 be the first edge at which a channel runs with pa=P (after enable/sync/halt). cnt is 0 entering E0.
  - `tick` is high during the cycle following edge E0+P−1, and every P cycles after that.
  - `sq` rises with each `tick` and falls after H cycles.
- After `en` rises with `period`=P stable:
  - First edge loads pa and holds cnt=0.
  - First tick appears P edges later.
- `sync` restarts all enabled channels on the same edge, so their ticks align from then on.
- `sync` asserted on a channel's wrap edge suppresses that tick. Sync wins.
- Reset assertion clears outputs immediately, independent of `clk`.
- Reset deassertion: first state change occurs on the first rising edge with `rst_n`=1.

## Test plan
- Reset, then en=1 on ch0 with period=4: tick0 is high 1 cycle in every 4, first tick 4 edges after the pa-load edge, and sq0 pattern is 1,1,0,0 repeating.
- Period=5 on ch1: sq1 is high 3 cycles and low 2. Period=1 on ch2: tick2 and sq2 held at 1. Period=0 on ch3: tick3 and sq3 stay 0, and cnt does not move.
- Running at period=8, change to 3 at cnt=2: the current period completes at 8 cycles, and subsequent periods are 3 cycles.
- Ch0 period=6 and ch1 period=9 free-running, pulse sync 1 cycle: both restart at cnt=0, and ticks coincide every 18 cycles. Sync on a wrap edge produces no tick.
- Deassert en mid-period: tick and sq go to 0 on the next edge. Re-enable: full-length first period.
- Assert rst_n=0 asynchronously mid-cycle: all tick and sq drop to 0 before the next edge. After release, behaviour matches the first scenario.
